// File: rtl/jtpopeye_funnel_sec.sv
// rtl/jtpopeye_funnel_sec.sv - Popeye-style protection funnel shifter with history, tap, direction and fill count
// CPU pushes words into a short history; reads return a shifted window over an adjacent entry pair.
module jtpopeye_funnel_sec #(
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          cs,
   input  logic [1:0]    addr,
   input  logic          rd_n,
   input  logic          wr_n,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   localparam int SW = $clog2(DW);
   localparam int TW = (DEPTH > 2) ? $clog2(DEPTH-1) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0]   r_hist [DEPTH];
   logic [SW-1:0]   r_shift;
   logic            r_dir;
   logic [TW-1:0]   r_tap;
   logic [CW-1:0]   r_count;
   logic [DW-1:0]   r_result;
   logic [DW-1:0]   r_dout;

   logic [TW-1:0]   w_t;
   logic [DW-1:0]   w_hi;
   logic [DW-1:0]   w_lo;
   logic [2*DW-1:0] w_cat;
   logic [2*DW-1:0] w_left;
   logic [2*DW-1:0] w_right;
   logic [DW-1:0]   w_win;
   logic            w_rd;
   logic            w_wr;

   assign w_rd = cen && cs && !rd_n;
   assign w_wr = cen && cs && !wr_n;

   // Taps beyond the last valid pair collapse onto the oldest pair.
   assign w_t = (r_tap > TW'(DEPTH-2)) ? TW'(DEPTH-2) : r_tap;

   always_comb begin
      w_hi = r_hist[0];
      w_lo = r_hist[1];
      for (int i = 0; i < DEPTH-1; i++) begin
         if (w_t == TW'(i)) begin
            w_hi = r_hist[i];
            w_lo = r_hist[i+1];
         end
      end
   end

   // Shifting the concatenated pair covers both funnel directions, including s=0.
   assign w_cat   = {w_hi, w_lo};
   assign w_left  = w_cat << r_shift;
   assign w_right = w_cat >> r_shift;
   assign w_win   = r_dir ? w_right[DW-1:0] : w_left[2*DW-1:DW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
         r_shift  <= '0;
         r_dir    <= 1'b0;
         r_tap    <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_dout   <= '0;
      end else if (cen) begin
         r_result <= w_win;
         if (w_rd) begin
            case (addr)
               2'd0:    r_dout <= r_result;
               2'd2:    r_dout <= DW'(r_count);
               default: r_dout <= '0;
            endcase
         end
         if (w_wr) begin
            case (addr)
               2'd0: begin
                  r_shift <= din[SW-1:0];
                  r_dir   <= din[SW];
                  r_tap   <= din[SW+TW:SW+1];
               end
               2'd1: begin
                  for (int i = DEPTH-1; i > 0; i--) r_hist[i] <= r_hist[i-1];
                  r_hist[0] <= din;
                  if (r_count < CW'(DEPTH)) r_count <= r_count + 1'b1;
               end
               2'd3: begin
                  for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
                  r_count <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign dout = r_dout;

endmodule

// File: tb/tb_jtpopeye_funnel_sec.sv
// tb/tb_jtpopeye_funnel_sec.sv - self-checking bench for jtpopeye_funnel_sec against an arithmetic reference model
module tb_jtpopeye_funnel_sec;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int MASK  = (1 << DW) - 1;

   logic          rst, clk, cen, cs, rd_n, wr_n;
   logic [1:0]    addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;

   int n_vec = 0;
   int n_err = 0;

   int hm [DEPTH];
   int cnt_m, sh_m, dir_m, tap_m, res_m, dout_m;

   jtpopeye_funnel_sec #(.DW(DW), .DEPTH(DEPTH)) dut (
      .rst(rst), .clk(clk), .cen(cen), .cs(cs), .addr(addr),
      .rd_n(rd_n), .wr_n(wr_n), .din(din), .dout(dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   function automatic int window();
      int t, hi, lo;
      t  = (tap_m > DEPTH-2) ? DEPTH-2 : tap_m;
      hi = hm[t];
      lo = hm[t+1];
      if (dir_m == 0) return ((hi << sh_m) | (lo >> (DW - sh_m))) & MASK;
      else            return ((lo >> sh_m) | (hi << (DW - sh_m))) & MASK;
   endfunction

   task automatic model_edge(input int r, c, s, a, rn, wn, d);
      int nres;
      if (r != 0) begin
         foreach (hm[i]) hm[i] = 0;
         cnt_m = 0; sh_m = 0; dir_m = 0; tap_m = 0; res_m = 0; dout_m = 0;
         return;
      end
      if (c == 0) return;
      nres = window();
      if (s != 0 && rn == 0)
         dout_m = (a == 0) ? res_m : (a == 2) ? cnt_m : 0;
      if (s != 0 && wn == 0) begin
         if (a == 0) begin
            sh_m  = d % DW;
            dir_m = (d / DW) % 2;
            tap_m = (d / (2*DW)) % 4;
         end else if (a == 1) begin
            for (int i = DEPTH-1; i > 0; i--) hm[i] = hm[i-1];
            hm[0] = d;
            if (cnt_m < DEPTH) cnt_m++;
         end else if (a == 3) begin
            foreach (hm[i]) hm[i] = 0;
            cnt_m = 0;
         end
      end
      res_m = nres;
   endtask

   task automatic step(input logic r, c, s, input logic [1:0] a,
                       input logic rn, wn, input logic [DW-1:0] d);
      rst = r; cen = c; cs = s; addr = a; rd_n = rn; wr_n = wn; din = d;
      @(posedge clk);
      model_edge(int'(r), int'(c), int'(s), int'(a), int'(rn), int'(wn), int'(d));
      #1;
      check("model", int'(dout), dout_m);
   endtask

   task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
      step(1'b0, 1'b1, 1'b1, a, 1'b1, 1'b0, d);
   endtask

   task automatic rd(input logic [1:0] a);
      step(1'b0, 1'b1, 1'b1, a, 1'b0, 1'b1, '0);
   endtask

   task automatic idle();
      step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, '0);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; cs = 1'b0; addr = '0; rd_n = 1'b1; wr_n = 1'b1; din = '0;
      foreach (hm[i]) hm[i] = 0;
      cnt_m = 0; sh_m = 0; dir_m = 0; tap_m = 0; res_m = 0; dout_m = 0;

      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, '0);
      rd(2'd0); check("reset_result", int'(dout), 0);
      rd(2'd2); check("reset_count", int'(dout), 0);

      wr(2'd1, 8'hA5); wr(2'd1, 8'h3C);
      wr(2'd0, 8'h03); idle(); rd(2'd0); check("left_s3", int'(dout), 8'hE5);
      wr(2'd0, 8'h00); idle(); rd(2'd0); check("left_s0", int'(dout), 8'h3C);
      wr(2'd0, 8'h0B); idle(); rd(2'd0); check("right_s3", int'(dout), 8'h94);
      wr(2'd0, 8'h08); idle(); rd(2'd0); check("right_s0", int'(dout), 8'hA5);

      foreach (hm[i]) wr(2'd1, 8'h11);
      wr(2'd1, 8'h11); wr(2'd1, 8'h22); wr(2'd1, 8'h33); wr(2'd1, 8'h44); wr(2'd1, 8'h55);
      rd(2'd2); check("count_sat", int'(dout), 4);
      wr(2'd0, 8'h20); idle(); rd(2'd0); check("tap2", int'(dout), 8'h33);
      wr(2'd0, 8'h30); idle(); rd(2'd0); check("tap3_clamp", int'(dout), 8'h33);
      wr(2'd0, 8'h04); idle(); rd(2'd0); check("tap0_s4", int'(dout), 8'h54);

      step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h20);
      check("rdwr_old", int'(dout), 8'h54);
      rd(2'd0); check("rdwr_next", int'(dout), 8'h54);
      rd(2'd0); check("rdwr_new", int'(dout), 8'h33);

      step(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 8'h77);
      rd(2'd2); check("cs0_count", int'(dout), 4);
      idle(); rd(2'd0); check("cs0_result", int'(dout), 8'h33);

      wr(2'd3, 8'h00); rd(2'd2); check("clear_count", int'(dout), 0);
      rd(2'd0); check("clear_result", int'(dout), 0);
      wr(2'd1, 8'h01); wr(2'd1, 8'h02); wr(2'd1, 8'h03);
      idle(); rd(2'd0); check("ctrl_kept", int'(dout), 8'h01);

      step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'h99);
      step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 8'h00);
      check("cen0_dout", int'(dout), 8'h01);
      rd(2'd2); check("cen0_count", int'(dout), 3);

      step(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 8'hFF);
      wr(2'd1, 8'h5A); rd(2'd2); check("post_reset_count", int'(dout), 1);

      for (int k = 0; k < 600; k++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              DW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
